ctrl_unit: RTL and testbench

//  Control sequencer for the 14-bit-instruction / 11-bit-PC core.

---
 rtl/ctrl_unit.sv | 195 +++++++++++++++++++
 tb/tb_ctrl_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// ctrl_unit: fixed four-phase instruction sequencer (T0 FETCH_A, T1 FETCH_B,
// T2 FETCH_C, T3 EXEC) for the 14-bit-instruction / 11-bit-PC core.
// Every output is registered. The strobes belonging to T-state n are
// captured while state reads n, so they appear in the following cycle.
// Optional feature macro: CTRL_CALL_EN adds the CALL/RETURN/RETLW return stack.
module ctrl_unit #(
    parameter int IR_W      = 14,
    parameter int PC_W      = 11,
    parameter int STK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [IR_W-1:0] ir,
    input  logic [PC_W-1:0] pc,
    output logic            load_mar,
    output logic            load_pc,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_target,
    output logic            load_ir,
    output logic            load_w,
    output logic [2:0]      alu_op,
    output logic [7:0]      literal,
    output logic            illegal,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        T0_FETCH_A = 2'd0,
        T1_FETCH_B = 2'd1,
        T2_FETCH_C = 2'd2,
        T3_EXEC    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic            load_mar_d, load_pc_d, pc_sel_d, load_ir_d, load_w_d, illegal_d;
    logic [PC_W-1:0] pc_target_d;
    logic [2:0]      alu_op_d;
    logic [7:0]      literal_d;
    logic [5:0]      opcode;

    assign opcode = ir[13:8];

`ifdef CTRL_CALL_EN
    localparam int SP_W = $clog2(STK_DEPTH);

    logic [PC_W-1:0] stack_mem [STK_DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_dec;
    logic            push_d, pop_d;

    assign sp_dec = sp_q - SP_W'(1);

    // Stack pointer: wraps modulo STK_DEPTH, so overflow overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push_d) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop_d) begin
            sp_q <= sp_dec;
        end
    end

    // Return-address storage, written with the current PC on CALL
    always_ff @(posedge clk) begin
        if (!rst && push_d) begin
            stack_mem[sp_q] <= pc;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= T0_FETCH_A;
            load_mar  <= 1'b0;
            load_pc   <= 1'b0;
            pc_sel    <= 1'b0;
            pc_target <= '0;
            load_ir   <= 1'b0;
            load_w    <= 1'b0;
            alu_op    <= '0;
            literal   <= '0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_mar  <= load_mar_d;
            load_pc   <= load_pc_d;
            pc_sel    <= pc_sel_d;
            pc_target <= pc_target_d;
            load_ir   <= load_ir_d;
            load_w    <= load_w_d;
            alu_op    <= alu_op_d;
            literal   <= literal_d;
            illegal   <= illegal_d;
        end
    end

    // Next state: fixed T0->T1->T2->T3->T0 ring, frozen while en=0
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                T0_FETCH_A: state_d = T1_FETCH_B;
                T1_FETCH_B: state_d = T2_FETCH_C;
                T2_FETCH_C: state_d = T3_EXEC;
                T3_EXEC:    state_d = T0_FETCH_A;
                default:    state_d = T0_FETCH_A;
            endcase
        end
    end

    // Output decode: fetch strobes by phase, instruction decode in T3
    always_comb begin
        load_mar_d  = 1'b0;
        load_pc_d   = 1'b0;
        pc_sel_d    = 1'b0;
        pc_target_d = '0;
        load_ir_d   = 1'b0;
        load_w_d    = 1'b0;
        alu_op_d    = 3'd0;
        literal_d   = '0;
        illegal_d   = 1'b0;
`ifdef CTRL_CALL_EN
        push_d      = 1'b0;
        pop_d       = 1'b0;
`endif
        if (en) begin
            unique case (state_q)
                T0_FETCH_A: load_mar_d = 1'b1;
                T1_FETCH_B: load_pc_d  = 1'b1;
                T2_FETCH_C: load_ir_d  = 1'b1;
                T3_EXEC: begin
                    casez (opcode)
                        6'b11_00??: begin load_w_d = 1'b1; alu_op_d = 3'd0; end
                        6'b11_1000: begin load_w_d = 1'b1; alu_op_d = 3'd4; end
                        6'b11_1001: begin load_w_d = 1'b1; alu_op_d = 3'd3; end
                        6'b11_1010: begin load_w_d = 1'b1; alu_op_d = 3'd5; end
                        6'b11_110?: begin load_w_d = 1'b1; alu_op_d = 3'd2; end
                        6'b11_111?: begin load_w_d = 1'b1; alu_op_d = 3'd1; end
                        6'b10_1???: begin
                            load_pc_d   = 1'b1;
                            pc_sel_d    = 1'b1;
                            pc_target_d = ir[PC_W-1:0];
                        end
`ifdef CTRL_CALL_EN
                        6'b10_0???: begin
                            push_d      = 1'b1;
                            load_pc_d   = 1'b1;
                            pc_sel_d    = 1'b1;
                            pc_target_d = ir[PC_W-1:0];
                        end
                        6'b11_01??: begin
                            pop_d       = 1'b1;
                            load_pc_d   = 1'b1;
                            pc_sel_d    = 1'b1;
                            pc_target_d = stack_mem[sp_dec];
                            load_w_d    = 1'b1;
                            alu_op_d    = 3'd0;
                        end
`endif
                        6'b00_0000: begin
                            if (ir[7:0] == 8'h00 || ir[7:0] == 8'h20 ||
                                ir[7:0] == 8'h40 || ir[7:0] == 8'h60) begin
                                illegal_d = 1'b0;
`ifdef CTRL_CALL_EN
                            end else if (ir[7:0] == 8'h08) begin
                                pop_d       = 1'b1;
                                load_pc_d   = 1'b1;
                                pc_sel_d    = 1'b1;
                                pc_target_d = stack_mem[sp_dec];
`endif
                            end else begin
                                illegal_d = 1'b1;
                            end
                        end
                        default: illegal_d = 1'b1;
                    endcase
                    if (load_w_d) begin
                        literal_d = ir[7:0];
                    end
                end
                default: illegal_d = 1'b0;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: table-driven scoreboard bench for ctrl_unit.
// Build with +define+CTRL_CALL_EN to exercise the return stack.
module tb_ctrl_unit;

    logic        clk, rst, en;
    logic [13:0] ir;
    logic [10:0] pc;
    logic        load_mar, load_pc, pc_sel, load_ir, load_w, illegal;
    logic [10:0] pc_target;
    logic [2:0]  alu_op;
    logic [7:0]  literal;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    ctrl_unit #(.IR_W(14), .PC_W(11), .STK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .ir(ir), .pc(pc),
        .load_mar(load_mar), .load_pc(load_pc), .pc_sel(pc_sel),
        .pc_target(pc_target), .load_ir(load_ir), .load_w(load_w),
        .alu_op(alu_op), .literal(literal), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic        mar, ldpc, sel;
        logic [10:0] tgt;
        logic        ldir, ldw;
        logic [2:0]  alu;
        logic [7:0]  lit;
        logic        ill;
    } obs_t;

    typedef struct {
        string       name;
        logic [13:0] ir;
        logic [10:0] pc;
        logic        ldpc, sel;
        logic [10:0] tgt;
        logic        ldw;
        logic [2:0]  alu;
        logic [7:0]  lit;
        logic        ill;
    } vec_t;

    obs_t  exp_q[$];
    string name_q[$];
    vec_t  table_q[$];

    function automatic obs_t mk(logic [1:0] st, logic mar, logic ldpc, logic sel,
                                logic [10:0] tgt, logic ldir, logic ldw,
                                logic [2:0] alu, logic [7:0] lit, logic ill);
        obs_t o;
        o = {st, mar, ldpc, sel, tgt, ldir, ldw, alu, lit, ill};
        return o;
    endfunction

    task automatic expect_obs(string n, obs_t o);
        exp_q.push_back(o);
        name_q.push_back(n);
    endtask

    task automatic add(string n, logic [13:0] i, logic [10:0] p, logic ldpc, logic sel,
                       logic [10:0] tgt, logic ldw, logic [2:0] alu, logic [7:0] lit,
                       logic ill);
        vec_t v;
        v.name = n; v.ir = i; v.pc = p; v.ldpc = ldpc; v.sel = sel; v.tgt = tgt;
        v.ldw = ldw; v.alu = alu; v.lit = lit; v.ill = ill;
        table_q.push_back(v);
    endtask

    // One clock: sample after the edge and compare against the oldest expectation
    task automatic cycle();
        obs_t a, e;
        string n;
        @(posedge clk);
        #1;
        a = {state, load_mar, load_pc, pc_sel, pc_target, load_ir, load_w, alu_op,
             literal, illegal};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%h required=<none>", a);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL %s got=%h required=%h (st,mar,ldpc,sel,tgt,ldir,ldw,alu,lit,ill)",
                         n, a, e);
            end
        end
    endtask

    // Full instruction starting from T0 with ir/pc held for all four phases
    task automatic run_instr(vec_t v);
        ir = v.ir;
        pc = v.pc;
        expect_obs({v.name, "_mar"}, mk(2'd1, 1, 0, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0));
        expect_obs({v.name, "_inc"}, mk(2'd2, 0, 1, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0));
        expect_obs({v.name, "_ir"},  mk(2'd3, 0, 0, 0, 11'h0, 1, 0, 3'd0, 8'h0, 0));
        expect_obs({v.name, "_exec"}, mk(2'd0, 0, v.ldpc, v.sel, v.tgt, 0, v.ldw, v.alu,
                                         v.lit, v.ill));
        for (int k = 0; k < 4; k++) cycle();
    endtask

    task automatic run_one(string n, logic [13:0] i, logic [10:0] p, logic ldpc,
                           logic sel, logic [10:0] tgt, logic ldw, logic [2:0] alu,
                           logic [7:0] lit, logic ill);
        vec_t v;
        v.name = n; v.ir = i; v.pc = p; v.ldpc = ldpc; v.sel = sel; v.tgt = tgt;
        v.ldw = ldw; v.alu = alu; v.lit = lit; v.ill = ill;
        run_instr(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef CTRL_CALL_EN
        logic [10:0] mstk [8];
        int          msp;
        logic [13:0] cir;
        logic [10:0] cpc;
`endif
        //   name      ir       pc      ldpc sel tgt      ldw alu   lit    ill
        add("movlw",   14'h3055, 11'h001, 0, 0, 11'h000, 1, 3'd0, 8'h55, 0);
        add("movlw2",  14'h33C3, 11'h002, 0, 0, 11'h000, 1, 3'd0, 8'hC3, 0);
        add("iorlw",   14'h38A5, 11'h003, 0, 0, 11'h000, 1, 3'd4, 8'hA5, 0);
        add("andlw",   14'h390F, 11'h004, 0, 0, 11'h000, 1, 3'd3, 8'h0F, 0);
        add("xorlw",   14'h3AFF, 11'h005, 0, 0, 11'h000, 1, 3'd5, 8'hFF, 0);
        add("sublw",   14'h3C12, 11'h006, 0, 0, 11'h000, 1, 3'd2, 8'h12, 0);
        add("sublw2",  14'h3D34, 11'h007, 0, 0, 11'h000, 1, 3'd2, 8'h34, 0);
        add("addlw",   14'h3E01, 11'h008, 0, 0, 11'h000, 1, 3'd1, 8'h01, 0);
        add("addlw2",  14'h3F80, 11'h009, 0, 0, 11'h000, 1, 3'd1, 8'h80, 0);
        add("goto",    14'h2ABC, 11'h00A, 1, 1, 11'h2BC, 0, 3'd0, 8'h00, 0);
        add("goto_max",14'h2FFF, 11'h2BD, 1, 1, 11'h7FF, 0, 3'd0, 8'h00, 0);
        add("goto_0",  14'h2800, 11'h000, 1, 1, 11'h000, 0, 3'd0, 8'h00, 0);
        add("nop00",   14'h0000, 11'h001, 0, 0, 11'h000, 0, 3'd0, 8'h00, 0);
        add("nop20",   14'h0020, 11'h002, 0, 0, 11'h000, 0, 3'd0, 8'h00, 0);
        add("nop40",   14'h0040, 11'h003, 0, 0, 11'h000, 0, 3'd0, 8'h00, 0);
        add("nop60",   14'h0060, 11'h004, 0, 0, 11'h000, 0, 3'd0, 8'h00, 0);
        add("ill0123", 14'h0123, 11'h005, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill0061", 14'h0061, 11'h006, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill0010", 14'h0010, 11'h007, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill1000", 14'h1000, 11'h008, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill3B00", 14'h3B00, 11'h009, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
`ifndef CTRL_CALL_EN
        add("ill_call",  14'h2000, 11'h00A, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill_call2", 14'h27FF, 11'h00B, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill_ret",   14'h0008, 11'h00C, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill_retlw", 14'h3400, 11'h00D, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
        add("ill_retlw2",14'h37FF, 11'h00E, 0, 0, 11'h000, 0, 3'd0, 8'h00, 1);
`endif

        // Reset held 5 cycles with en=1: everything stays at reset values
        rst = 1'b1; en = 1'b1; ir = 14'h3055; pc = 11'h000;
        for (int k = 0; k < 5; k++) begin
            expect_obs("reset", mk(2'd0, 0, 0, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0));
            cycle();
        end
        rst = 1'b0;

        foreach (table_q[i]) run_instr(table_q[i]);

        // en dropped in T2 for 3 cycles, then MOVLW completes
        ir = 14'h3055; pc = 11'h010;
        expect_obs("hold_mar", mk(2'd1, 1, 0, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0)); cycle();
        expect_obs("hold_inc", mk(2'd2, 0, 1, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0)); cycle();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_obs("hold_frozen", mk(2'd2, 0, 0, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0));
            cycle();
        end
        en = 1'b1;
        expect_obs("hold_resume_ir", mk(2'd3, 0, 0, 0, 11'h0, 1, 0, 3'd0, 8'h0, 0)); cycle();
        expect_obs("hold_exec", mk(2'd0, 0, 0, 0, 11'h0, 0, 1, 3'd0, 8'h55, 0)); cycle();

        // Reset asserted while in T3 with an illegal opcode pending
        ir = 14'h0123; pc = 11'h020;
        expect_obs("rst3_mar", mk(2'd1, 1, 0, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0)); cycle();
        expect_obs("rst3_inc", mk(2'd2, 0, 1, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0)); cycle();
        expect_obs("rst3_ir",  mk(2'd3, 0, 0, 0, 11'h0, 1, 0, 3'd0, 8'h0, 0)); cycle();
        rst = 1'b1;
        expect_obs("rst3_clear", mk(2'd0, 0, 0, 0, 11'h0, 0, 0, 3'd0, 8'h0, 0)); cycle();
        rst = 1'b0;
        run_one("after_rst", 14'h3A0F, 11'h000, 0, 0, 11'h000, 1, 3'd5, 8'h0F, 0);

`ifdef CTRL_CALL_EN
        // CALL 0x100 from pc 0x011, then RETURN
        run_one("call",   14'h2100, 11'h011, 1, 1, 11'h100, 0, 3'd0, 8'h00, 0);
        run_one("return", 14'h0008, 11'h101, 1, 1, 11'h011, 0, 3'd0, 8'h00, 0);
        // CALL then RETLW 0x77
        run_one("call2",  14'h2233, 11'h055, 1, 1, 11'h233, 0, 3'd0, 8'h00, 0);
        run_one("retlw",  14'h3477, 11'h234, 1, 1, 11'h055, 1, 3'd0, 8'h77, 0);
        // 9 nested CALLs overflow an 8-deep stack, then 9 RETURNs
        msp = 0;
        for (int i = 0; i < 9; i++) begin
            cir = 14'h2000 | 14'(i * 8);
            cpc = 11'h040 + 11'(i);
            mstk[msp] = cpc;
            msp = (msp + 1) % 8;
            run_one("nest_call", cir, cpc, 1, 1, 11'(i * 8), 0, 3'd0, 8'h00, 0);
        end
        for (int i = 0; i < 9; i++) begin
            msp = (msp + 7) % 8;
            run_one((i == 8) ? "nest_ret9_wrap" : "nest_ret", 14'h0008, 11'h300,
                    1, 1, mstk[msp], 0, 3'd0, 8'h00, 0);
        end
        if (mstk[msp] !== 11'h048) begin
            checks++;
            failures++;
            $display("FAIL model_wrap got=%h required=048", mstk[msp]);
        end
`endif

        // Final NOP confirms pc_sel returns to 0 after redirects
        run_one("final_nop", 14'h0000, 11'h000, 0, 0, 11'h000, 0, 3'd0, 8'h00, 0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
